// File: rtl/cic_interp_sequencer.sv
// CIC interpolator front-end: zero-stuffs samples by R at a divided strobe rate.
// Optional underrun counter port enabled by define CIC_SEQ_UNDERRUN_CNT_EN.
module cic_interp_sequencer #(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 25,
  parameter int N      = 32,
  parameter int DIV_W  = 16,
  parameter int RATE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [RATE_W-1:0] cfg_rate,
  input  logic              start,
  input  logic              stop,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [IN_W-1:0]   s_data,
  output logic              core_en,
  output logic [OUT_W-1:0]  core_data,
  output logic              busy,
  output logic              underrun
`ifdef CIC_SEQ_UNDERRUN_CNT_EN
  ,
  output logic [15:0]       underrun_cnt
`endif
);

  localparam int CW = $clog2(N + 4);
  localparam logic [CW-1:0] LAST = CW'(N + 2);

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    RUN,
    DRAIN
  } state_t;

  state_t             state, state_n;
  logic [DIV_W-1:0]   div_q, div_n;
  logic [RATE_W-1:0]  rate_q, rate_n;
  logic [DIV_W-1:0]   div_cnt, div_cnt_n;
  logic [RATE_W-1:0]  phase, phase_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic               stop_pend, stop_pend_n;
  logic               en_n, und_n;
  logic [OUT_W-1:0]   data_n;
  logic               tick;
  logic signed [OUT_W-1:0] ext;

  assign ext  = OUT_W'($signed(s_data));
  assign busy = (state != IDLE);
  assign tick = busy && (div_cnt == div_q - 1'b1);

  assign s_ready = (state == RUN) && tick &&
                   (phase == '0) && !stop_pend;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      div_q     <= DIV_W'(1);
      rate_q    <= RATE_W'(1);
      div_cnt   <= '0;
      phase     <= '0;
      cnt       <= '0;
      stop_pend <= 1'b0;
      core_en   <= 1'b0;
      core_data <= '0;
      underrun  <= 1'b0;
    end else begin
      state     <= state_n;
      div_q     <= div_n;
      rate_q    <= rate_n;
      div_cnt   <= div_cnt_n;
      phase     <= phase_n;
      cnt       <= cnt_n;
      stop_pend <= stop_pend_n;
      core_en   <= en_n;
      core_data <= data_n;
      underrun  <= und_n;
    end
  end

  always_comb begin
    state_n     = state;
    div_n       = div_q;
    rate_n      = rate_q;
    div_cnt_n   = div_cnt;
    phase_n     = phase;
    cnt_n       = cnt;
    stop_pend_n = stop_pend;
    en_n        = 1'b0;
    data_n      = core_data;
    und_n       = 1'b0;

    if (busy) begin
      div_cnt_n = tick ? '0 : div_cnt + 1'b1;
      if (stop)
        stop_pend_n = 1'b1;
    end

    unique case (state)
      IDLE: begin
        if (start) begin
          div_n       = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
          rate_n      = (cfg_rate == '0) ? RATE_W'(1) : cfg_rate;
          div_cnt_n   = '0;
          phase_n     = '0;
          cnt_n       = '0;
          stop_pend_n = 1'b0;
          state_n     = FLUSH;
        end
      end
      FLUSH: begin
        if (tick) begin
          en_n   = 1'b1;
          data_n = '0;
          if (cnt == LAST) begin
            cnt_n   = '0;
            phase_n = '0;
            state_n = stop_pend ? DRAIN : RUN;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      RUN: begin
        if (tick) begin
          en_n   = 1'b1;
          data_n = '0;
          if (phase == '0 && stop_pend) begin
            // This tick is the first of the drain sequence.
            state_n = DRAIN;
            cnt_n   = CW'(1);
          end else begin
            if (phase == '0) begin
              if (s_valid)
                data_n = ext;
              else
                und_n = 1'b1;
            end
            phase_n = (phase == rate_q - 1'b1) ? '0 : phase + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (tick) begin
          en_n   = 1'b1;
          data_n = '0;
          if (cnt == LAST) begin
            state_n     = IDLE;
            cnt_n       = '0;
            div_cnt_n   = '0;
            stop_pend_n = 1'b0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef CIC_SEQ_UNDERRUN_CNT_EN
  logic start_ok;
  assign start_ok = (state == IDLE) && start;

  always_ff @(posedge clk) begin
    if (!rst_n)
      underrun_cnt <= '0;
    else if (start_ok)
      underrun_cnt <= '0;
    else if (underrun && underrun_cnt != 16'hFFFF)
      underrun_cnt <= underrun_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_cic_interp_sequencer.sv
// Scoreboard bench for cic_interp_sequencer with a strobe-count reference model.
// Also checks underrun_cnt when CIC_SEQ_UNDERRUN_CNT_EN is defined.
module tb_cic_interp_sequencer;
  localparam int IN_W   = 16;
  localparam int OUT_W  = 25;
  localparam int N      = 32;
  localparam int DIV_W  = 16;
  localparam int RATE_W = 8;
  localparam int FL     = N + 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DIV_W-1:0]  cfg_div = '0;
  logic [RATE_W-1:0] cfg_rate = '0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [IN_W-1:0]   s_data = '0;
  logic              core_en;
  logic [OUT_W-1:0]  core_data;
  logic              busy;
  logic              underrun;
`ifdef CIC_SEQ_UNDERRUN_CNT_EN
  logic [15:0]       underrun_cnt;
`endif

  cic_interp_sequencer #(
    .IN_W(IN_W), .OUT_W(OUT_W), .N(N),
    .DIV_W(DIV_W), .RATE_W(RATE_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_div(cfg_div), .cfg_rate(cfg_rate),
    .start(start), .stop(stop),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .core_en(core_en), .core_data(core_data),
    .busy(busy), .underrun(underrun)
`ifdef CIC_SEQ_UNDERRUN_CNT_EN
    , .underrun_cnt(underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OUT_W-1:0] d;
    logic             u;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // reference model: counts cycles and strobes of a session
  bit m_act = 0;
  bit m_stop = 0;
  int m_div = 1, m_rate = 1;
  int m_n = 0, m_k = 0, m_j = 0, m_mode = 0, m_left = 0;
  int m_ucnt = 0;
  logic [IN_W-1:0] cur = '0;
  logic [IN_W-1:0] pre_q[$];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [OUT_W-1:0] sext(logic [IN_W-1:0] x);
    return {{(OUT_W-IN_W){x[IN_W-1]}}, x};
  endfunction

  task automatic push(logic [OUT_W-1:0] d, logic u);
    exp_t e;
    e.d = d;
    e.u = u;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (core_en) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL strobe_unexpected got=%0h want=none t=%0t",
                 core_data, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("core_data", core_data, e.d);
        chk("underrun", underrun, e.u);
      end
    end else if (underrun) begin
      chk("underrun_stray", underrun, 0);
    end
  end

  task automatic step(bit st, bit sp, bit v, bit rs);
    bit tick;
    bit er;
    @(negedge clk);
    start   = st;
    stop    = sp;
    s_valid = v;
    rst_n   = !rs;
    s_data  = cur;
    #1;
    tick = 0;
    er   = 0;
    if (m_act) begin
      tick = ((m_n + 1) % m_div) == 0;
      er = tick && m_mode == 1 && (m_j % m_rate) == 0 && !m_stop;
    end
    chk("busy", busy, m_act);
    chk("s_ready", s_ready, er);
`ifdef CIC_SEQ_UNDERRUN_CNT_EN
    if (!m_act || m_mode == 0)
      chk("underrun_cnt", underrun_cnt, m_ucnt);
`endif
    if (rs) begin
      chk("q_empty_at_reset", q.size(), 0);
      m_act  = 0;
      m_stop = 0;
      m_ucnt = 0;
    end else if (!m_act) begin
      if (st) begin
        m_act  = 1;
        m_stop = 0;
        m_div  = (cfg_div == 0) ? 1 : int'(cfg_div);
        m_rate = (cfg_rate == 0) ? 1 : int'(cfg_rate);
        m_n = 0; m_k = 0; m_j = 0; m_mode = 0;
        m_ucnt = 0;
      end
    end else begin
      m_n++;
      if (tick) begin
        case (m_mode)
          0: begin
            push('0, 0);
            m_k++;
            if (m_k == FL) begin
              if (m_stop) begin
                m_mode = 2;
                m_left = FL;
              end else begin
                m_mode = 1;
                m_j = 0;
              end
            end
          end
          1: begin
            if ((m_j % m_rate) == 0 && m_stop) begin
              push('0, 0);
              m_mode = 2;
              m_left = FL - 1;
            end else begin
              if ((m_j % m_rate) == 0) begin
                if (v) begin
                  push(sext(cur), 0);
                  if (pre_q.size() > 0) cur = pre_q.pop_front();
                  else cur = IN_W'($urandom);
                end else begin
                  push('0, 1);
                  if (m_ucnt < 16'hFFFF) m_ucnt++;
                end
              end else begin
                push('0, 0);
              end
              m_j++;
            end
          end
          default: begin
            push('0, 0);
            m_left--;
            if (m_left == 0) begin
              m_act  = 0;
              m_stop = 0;
            end
          end
        endcase
      end
      if (sp && m_act) m_stop = 1;
    end
  endtask

  task automatic session(int d, int r, int vpct, int stop_at, bit rst_drain);
    int guard;
    bit sp, rs, st;
    guard = 0;
    cfg_div  = DIV_W'(d);
    cfg_rate = RATE_W'(r);
    step(1, 0, 0, 0);
    while (m_act && guard < 20000) begin
      sp = (m_n + 1 == stop_at);
      rs = rst_drain && m_mode == 2 && m_left == 10;
      st = ($urandom % 16) == 0;
      step(st, sp, ($urandom % 100) < vpct, rs);
      guard++;
    end
    if (m_act) begin
      n_cmp++;
      n_bad++;
      $display("FAIL session_timeout got=busy want=idle");
      m_act = 0;
    end
    repeat (3) step(0, 0, 0, 0);
  endtask

  initial begin
    repeat (3) step(0, 0, 0, 1);
    chk("rst_core_en", core_en, 0);
    chk("rst_core_data", core_data, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_busy", busy, 0);
    step(0, 1, 0, 0);
    chk("stop_in_idle", busy, 0);

    // idle input: three missed phase-0 ticks
    session(1, 4, 0, FL + 10, 0);
    // fixed pattern 8001, 0005 then random, div 3
    cur = 16'h8001;
    pre_q.push_back(16'h0005);
    session(3, 4, 100, FL * 3 + 60, 0);
    // zero config treated as 1/1
    session(0, 0, 70, FL + 40, 0);
    // stop at phase 2 of R=4
    session(1, 4, 100, FL + 11, 0);
    // stop during flush
    session(2, 3, 100, 10, 0);
    // reset in drain, then full session
    session(2, 3, 60, 2 * FL + 20, 1);
    session(1, 2, 50, FL + 30, 0);
    for (int i = 0; i < 6; i++) begin
      int d, r;
      d = $urandom_range(0, 4);
      r = $urandom_range(0, 5);
      session(d, r, $urandom_range(0, 100),
              $urandom_range(1, FL * (d == 0 ? 1 : d) + 80), 0);
    end
    repeat (4) step(0, 0, 0, 0);
    chk("q_empty_end", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
